// File: rtl/shared_program_memory.sv
// shared_program_memory
// Loadable program store shared by NUM_CORES cores. A loader streams an
// image through a valid/ready port. A three-state FSM (EMPTY/LOAD/READY)
// tracks the load, and the cores stay held until a complete image is present.
// Each core has its own read port. READ_REG selects a combinational or a
// registered read.
module shared_program_memory #(
    parameter int                NUM_CORES = 8,
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 256,
    parameter bit                READ_REG  = 1'b0,
    parameter logic [DATA_W-1:0] NOP_VALUE = 8'b0111_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ld_start,
    input  logic [ADDR_W:0]               ld_len,
    input  logic                          ld_valid,
    input  logic [DATA_W-1:0]             ld_data,
    output logic                          ld_ready,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    output logic [NUM_CORES*DATA_W-1:0]   core_data,
    output logic                          core_hold,
    output logic                          mem_ready,
    output logic [ADDR_W:0]               ld_count,
    output logic [DATA_W-1:0]             ld_checksum,
    output logic                          ld_error
);

    // Index width of the storage array. A one-word array still gets one index bit.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W:0]     r_wr_ptr;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_count;
    logic [DATA_W-1:0]   r_checksum;
    logic                r_error;

    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_len_ok;
    logic                w_start_ok;
    logic                w_start_bad;
    logic                w_accept;
    logic                w_last;

    // Load-side handshake and start decode. ld_start has no effect while in LOAD.
    assign w_len_ok    = (ld_len != '0) && (ld_len <= DEPTH_W);
    assign w_start_ok  = ld_start && (r_state != LOAD) && w_len_ok;
    assign w_start_bad = ld_start && (r_state != LOAD) && !w_len_ok;
    assign ld_ready    = (r_state == LOAD);
    assign w_accept    = reset && ld_ready && ld_valid;
    assign w_last      = w_accept && ((r_wr_ptr + PTR_ONE) == r_len);

    assign mem_ready   = (r_state == READY);
    assign core_hold   = !mem_ready;
    assign ld_count    = r_count;
    assign ld_checksum = r_checksum;
    assign ld_error    = r_error;

    // State register. An active-low synchronous reset returns to EMPTY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A rejected start leaves the current state unchanged.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (w_start_ok) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (w_last) begin
                    w_state_next = READY;
                end
            end
            READY: begin
                if (w_start_ok) begin
                    w_state_next = LOAD;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
    end

    // Load bookkeeping: write pointer, latched length, count, checksum, sticky error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_checksum <= '0;
            r_error    <= 1'b0;
        end else if (w_start_ok) begin
            r_wr_ptr   <= '0;
            r_len      <= ld_len;
            r_count    <= '0;
            r_checksum <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_start_bad) begin
                r_error <= 1'b1;
            end
            if (w_accept) begin
                r_wr_ptr   <= r_wr_ptr + PTR_ONE;
                r_checksum <= r_checksum + ld_data;
                if (r_count < DEPTH_W) begin
                    r_count <= r_count + PTR_ONE;
                end
            end
        end
    end

    // Image storage. Reset does not clear it, so words already written survive an aborted load.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= ld_data;
        end
    end

    // One independent read port per core.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
            logic [ADDR_W-1:0] w_addr;
            logic              w_in_range;
            logic [DATA_W-1:0] w_word;

            assign w_addr     = core_addr[gi*ADDR_W +: ADDR_W];
            assign w_in_range = ({1'b0, w_addr} < DEPTH_W);
            assign w_word     = (core_hold || !w_in_range) ? NOP_VALUE
                                                           : r_mem[w_addr[IDX_W-1:0]];

            if (READ_REG) begin : g_reg
                logic [DATA_W-1:0] r_data;

                // Registered read. The output uses the address and hold sampled at the previous edge.
                always_ff @(posedge clk) begin
                    if (!reset) begin
                        r_data <= NOP_VALUE;
                    end else begin
                        r_data <= w_word;
                    end
                end

                assign core_data[gi*DATA_W +: DATA_W] = r_data;
            end else begin : g_comb
                assign core_data[gi*DATA_W +: DATA_W] = w_word;
            end
        end
    endgenerate

endmodule

// File: tb/tb_shared_program_memory.sv
// Directed testbench for shared_program_memory. It instantiates a
// combinational-read copy and a registered-read copy (both DEPTH=128) and
// drives the same load and address stimulus into both.
module tb_shared_program_memory;

    localparam int NC  = 8;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int DEP = 128;
    localparam logic [7:0] NOP = 8'h70;

    logic              clk;
    logic              reset;
    logic              ld_start;
    logic [AW:0]       ld_len;
    logic              ld_valid;
    logic [DW-1:0]     ld_data;
    logic [NC*AW-1:0]  core_addr;

    logic              c_ld_ready, r_ld_ready;
    logic [NC*DW-1:0]  c_core_data, r_core_data;
    logic              c_core_hold, r_core_hold;
    logic              c_mem_ready, r_mem_ready;
    logic [AW:0]       c_ld_count, r_ld_count;
    logic [DW-1:0]     c_ld_checksum, r_ld_checksum;
    logic              c_ld_error, r_ld_error;

    int n_cmp = 0;
    int n_err = 0;

    shared_program_memory #(
        .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP),
        .READ_REG(1'b0), .NOP_VALUE(NOP)
    ) dut_c (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(c_ld_ready),
        .core_addr(core_addr), .core_data(c_core_data), .core_hold(c_core_hold),
        .mem_ready(c_mem_ready), .ld_count(c_ld_count),
        .ld_checksum(c_ld_checksum), .ld_error(c_ld_error)
    );

    shared_program_memory #(
        .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP),
        .READ_REG(1'b1), .NOP_VALUE(NOP)
    ) dut_r (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(r_ld_ready),
        .core_addr(core_addr), .core_data(r_core_data), .core_hold(r_core_hold),
        .mem_ready(r_mem_ready), .ld_count(r_ld_count),
        .ld_checksum(r_ld_checksum), .ld_error(r_ld_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-24s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_addr(input int core, input int a);
        core_addr[core*AW +: AW] = a[AW-1:0];
    endtask

    function automatic logic [7:0] cd(input int core);
        return c_core_data[core*DW +: DW];
    endfunction

    function automatic logic [7:0] rd(input int core);
        return r_core_data[core*DW +: DW];
    endfunction

    task automatic start(input int len);
        ld_start = 1'b1;
        ld_len   = len[AW:0];
        step();
        ld_start = 1'b0;
    endtask

    task automatic push(input int d);
        ld_valid = 1'b1;
        ld_data  = d[DW-1:0];
        step();
        ld_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        ld_start  = 1'b0;
        ld_len    = '0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        core_addr = '0;
        step();
        step();

        // Reset state
        chk("rst mem_ready", c_mem_ready, 0);
        chk("rst core_hold", c_core_hold, 1);
        chk("rst ld_ready", c_ld_ready, 0);
        chk("rst ld_count", c_ld_count, 0);
        chk("rst ld_checksum", c_ld_checksum, 0);
        chk("rst ld_error", c_ld_error, 0);
        chk("rst comb core0", cd(0), NOP);
        chk("rst reg core0", rd(0), NOP);
        reset = 1'b1;
        step();

        // Test 1: four back-to-back words
        start(4);
        chk("t1 hold after start", c_core_hold, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1 ld_ready w%0d", i), c_ld_ready, 1);
            chk($sformatf("t1 mem_ready w%0d", i), c_mem_ready, 0);
            push(20 + i);
        end
        chk("t1 mem_ready", c_mem_ready, 1);
        chk("t1 core_hold", c_core_hold, 0);
        chk("t1 ld_ready", c_ld_ready, 0);
        chk("t1 ld_count", c_ld_count, 4);
        chk("t1 ld_checksum", c_ld_checksum, 86);

        // Test 2: seven cores read addr 2, core 7 reads out of range
        for (int i = 0; i < 7; i++) set_addr(i, 2);
        set_addr(7, 200);
        #1;
        for (int i = 0; i < 7; i++) chk($sformatf("t2 comb core%0d", i), cd(i), 22);
        chk("t2 comb core7 oor", cd(7), NOP);
        step();
        chk("t2 reg core0", rd(0), 22);
        chk("t2 reg core6", rd(6), 22);
        chk("t2 reg core7 oor", rd(7), NOP);

        // Test 3: illegal lengths while READY
        start(0);
        chk("t3 len0 error", c_ld_error, 1);
        chk("t3 len0 mem_ready", c_mem_ready, 1);
        chk("t3 len0 core0", cd(0), 22);
        start(DEP + 1);
        chk("t3 len129 error", c_ld_error, 1);
        chk("t3 len129 mem_ready", c_mem_ready, 1);
        chk("t3 len129 ld_count", c_ld_count, 4);
        chk("t3 len129 core1", cd(1), 22);

        // Test 4: three-word load with valid pattern 1,0,0,1,1
        start(3);
        chk("t4 error cleared", c_ld_error, 0);
        chk("t4 mem_ready low", c_mem_ready, 0);
        chk("t4 ld_count zero", c_ld_count, 0);
        chk("t4 held core0", cd(0), NOP);
        push(5);
        ld_data = 8'd99; step();
        ld_data = 8'd98; step();
        chk("t4 count after stall", c_ld_count, 1);
        push(6);
        chk("t4 mem_ready after 2", c_mem_ready, 0);
        chk("t4 count after 2", c_ld_count, 2);
        push(7);
        chk("t4 mem_ready", c_mem_ready, 1);
        chk("t4 ld_count", c_ld_count, 3);
        chk("t4 ld_checksum", c_ld_checksum, 18);
        for (int i = 0; i < 4; i++) set_addr(i, i);
        #1;
        chk("t4 mem0", cd(0), 5);
        chk("t4 mem1", cd(1), 6);
        chk("t4 mem2", cd(2), 7);
        chk("t4 mem3 old", cd(3), 23);

        // Test 5: reset after 2 of 5 words, then a full load
        start(5);
        push(40);
        push(41);
        chk("t5 count mid", c_ld_count, 2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t5 mem_ready", c_mem_ready, 0);
        chk("t5 core_hold", c_core_hold, 1);
        chk("t5 ld_ready", c_ld_ready, 0);
        chk("t5 ld_count", c_ld_count, 0);
        chk("t5 comb core0", cd(0), NOP);
        chk("t5 reg core0", rd(0), NOP);
        push(77);
        chk("t5 no accept empty", c_ld_count, 0);
        start(2);
        push(50);
        push(51);
        chk("t5 reload ready", c_mem_ready, 1);
        chk("t5 reload checksum", c_ld_checksum, 101);
        chk("t5 mem0", cd(0), 50);
        chk("t5 mem1", cd(1), 51);
        chk("t5 mem2 aborted", cd(2), 7);

        // Test 6: registered read latency
        set_addr(0, 0);
        step();
        chk("t6 reg addr0", rd(0), 50);
        set_addr(0, 1);
        #1;
        chk("t6 comb addr1 now", cd(0), 51);
        chk("t6 reg still addr0", rd(0), 50);
        step();
        chk("t6 reg addr1", rd(0), 51);
        start(1);
        chk("t6 reg edge of start", rd(0), 51);
        step();
        chk("t6 reg held", rd(0), NOP);
        push(9);
        chk("t6 reg ready edge", rd(0), NOP);
        chk("t6 ready", r_mem_ready, 1);
        step();
        chk("t6 reg after ready", rd(0), 51);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
